// File: rtl/detect_share_arbiter_pkg.sv
// Shared types and constants for the time-shared 1101 detector arbiter.
package detect_pkg;

    // Detector states. ID110 -> ID1 on x=1 is the overlapping-hit transition.
    typedef enum logic [1:0] {
        START = 2'b00,
        ID1   = 2'b01,
        ID11  = 2'b11,
        ID110 = 2'b10
    } det_state_t;

    localparam logic FOUND    = 1'b1;
    localparam logic NOTFOUND = 1'b0;

    // Controller FSM encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARB   = 2'b01,
        SERVE = 2'b10
    } ctl_state_t;

    // Saturating 8-bit increment used for the hit counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/detect_share_arbiter_step.sv
// One step of the 1101 Mealy detector: pure combinational next-state and hit.
module detect_1101_step
    import detect_pkg::*;
(
    input  logic [1:0] state,
    input  logic       x,
    output logic [1:0] next_state,
    output logic       hit
);

    det_state_t cur;
    assign cur = det_state_t'(state);

    // Next-state/hit table; hit only on ID110 with x=1.
    always_comb begin
        next_state = START;
        hit        = NOTFOUND;
        unique case (cur)
            START: next_state = x ? ID1  : START;
            ID1:   next_state = x ? ID11 : START;
            ID11:  next_state = x ? ID11 : ID110;
            ID110: begin
                next_state = x ? ID1 : START;
                hit        = x ? FOUND : NOTFOUND;
            end
            default: next_state = START;
        endcase
    end

endmodule

// File: rtl/detect_share_arbiter.sv
// Round-robin arbiter that time-shares one 1101 detector among N_REQ serial
// requesters, saving each requester's detector state between grants.
module detect_share_arbiter
    import detect_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int BURST = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         bit_in,
    output logic [N_REQ-1:0]         grant,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] found_id,
    output logic [7:0]               hit_count,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N_REQ);

    ctl_state_t       ctl_q, ctl_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [1:0]       cur_q, cur_d;
    logic [7:0]       bit_cnt_q, bit_cnt_d;
    logic             found_q, found_d;
    logic [IDX_W-1:0] found_id_q, found_id_d;
    logic [7:0]       hit_count_q, hit_count_d;
    logic [1:0]       ctx_q [N_REQ];
    logic             ctx_we;

    logic [IDX_W-1:0] sel;
    logic             sel_valid;
    logic [1:0]       step_next;
    logic             step_hit;
    logic             consume;
    logic             burst_done;

    // The single shared detector, fed from the granted requester's line.
    detect_1101_step u_step (
        .state      (cur_q),
        .x          (bit_in[gnt_idx_q]),
        .next_state (step_next),
        .hit        (step_hit)
    );

    assign consume    = (ctl_q == SERVE) && req[gnt_idx_q];
    assign burst_done = consume && (({1'b0, bit_cnt_q} + 9'd1) == 9'(BURST));

    // Round-robin pick: first requester at or after last+1, wrapping.
    always_comb begin
        logic [IDX_W-1:0] cand;
        sel       = '0;
        sel_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N_REQ);
            if (!sel_valid && req[cand]) begin
                sel       = cand;
                sel_valid = 1'b1;
            end
        end
    end

    // Controller next-state: arbitration, serial stepping, exit and context save.
    always_comb begin
        ctl_d       = ctl_q;
        gnt_idx_d   = gnt_idx_q;
        last_d      = last_q;
        cur_d       = cur_q;
        bit_cnt_d   = bit_cnt_q;
        found_d     = NOTFOUND;
        found_id_d  = found_id_q;
        hit_count_d = hit_count_q;
        ctx_we      = 1'b0;
        unique case (ctl_q)
            IDLE: begin
                if (|req) ctl_d = ARB;
            end
            ARB: begin
                if (sel_valid) begin
                    cur_d     = ctx_q[sel];
                    gnt_idx_d = sel;
                    bit_cnt_d = '0;
                    ctl_d     = SERVE;
                end else begin
                    ctl_d = IDLE;
                end
            end
            SERVE: begin
                if (consume) begin
                    cur_d     = step_next;
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (step_hit) begin
                        found_d     = FOUND;
                        found_id_d  = gnt_idx_q;
                        hit_count_d = sat_inc8(hit_count_q);
                    end
                end
                // Leaving: cur_d already holds the post-step state to save.
                if (!req[gnt_idx_q] || burst_done) begin
                    ctx_we = 1'b1;
                    last_d = gnt_idx_q;
                    ctl_d  = (|req) ? ARB : IDLE;
                end
            end
            default: ctl_d = IDLE;
        endcase
    end

    // Controller and detector-path registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q       <= IDLE;
            gnt_idx_q   <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            cur_q       <= START;
            bit_cnt_q   <= '0;
            found_q     <= NOTFOUND;
            found_id_q  <= '0;
            hit_count_q <= '0;
        end else begin
            ctl_q       <= ctl_d;
            gnt_idx_q   <= gnt_idx_d;
            last_q      <= last_d;
            cur_q       <= cur_d;
            bit_cnt_q   <= bit_cnt_d;
            found_q     <= found_d;
            found_id_q  <= found_id_d;
            hit_count_q <= hit_count_d;
        end
    end

    // Per-requester saved detector context, written when its grant ends.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ctx
            always_ff @(posedge clk) begin
                if (reset) begin
                    ctx_q[gi] <= START;
                end else if (ctx_we && (gnt_idx_q == IDX_W'(gi))) begin
                    ctx_q[gi] <= cur_d;
                end
            end
        end
    endgenerate

    // Grant decode: one-hot while serving, zero otherwise.
    always_comb begin
        grant = '0;
        if (ctl_q == SERVE) grant[gnt_idx_q] = 1'b1;
    end

    assign busy      = (ctl_q == SERVE);
    assign found     = found_q;
    assign found_id  = found_id_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_detect_share_arbiter.sv
// Scoreboard bench for detect_share_arbiter (N_REQ=4, BURST=8).
module tb_detect_share_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR-1:0] bit_in;
    logic [NR-1:0] grant;
    logic          found;
    logic [1:0]    found_id;
    logic [7:0]    hit_count;
    logic          busy;

    detect_share_arbiter #(.N_REQ(NR), .BURST(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bit_in    (bit_in),
        .grant     (grant),
        .found     (found),
        .found_id  (found_id),
        .hit_count (hit_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] cnt;
    } exp_t;

    exp_t          expq [$];
    bit            bq [NR][$];
    int            cons_cnt [NR];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    bit            log_en = 1'b0;
    logic [NR-1:0] glog [$];

    // Monitor: grant log and scoreboard comparison of every found pulse.
    always @(negedge clk) begin
        exp_t e;
        if (log_en) glog.push_back(grant);
        if (found === 1'b1) begin
            checks = checks + 1;
            if (expq.size() == 0) begin
                errors = errors + 1;
                $display("FAIL found_unexpected: got id=%0d count=%0d, required no hit", found_id, hit_count);
            end else begin
                e = expq.pop_front();
                if (found_id !== e.id || hit_count !== e.cnt) begin
                    errors = errors + 1;
                    $display("FAIL found_event: got id=%0d count=%0d, required id=%0d count=%0d",
                             found_id, hit_count, e.id, e.cnt);
                end else begin
                    $display("hit id=%0d count=%0d ok", found_id, hit_count);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < NR; i++) if (bq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: retire consumed bits, then present next bits / req levels.
    task automatic tick();
        logic [NR-1:0] cons;
        @(negedge clk);
        cons = grant & req;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (cons[i]) begin
                if (bq[i].size() > 0) void'(bq[i].pop_front());
                cons_cnt[i] = cons_cnt[i] + 1;
            end
        end
        for (int i = 0; i < NR; i++) begin
            req[i]    = (bq[i].size() > 0);
            bit_in[i] = (bq[i].size() > 0) ? bq[i][0] : 1'b0;
        end
    endtask

    task automatic load(input int id, input int n, input logic [31:0] pat);
        for (int k = n - 1; k >= 0; k--) bq[id].push_back(pat[k]);
    endtask

    task automatic push_exp(input int id, input int cnt);
        exp_t e;
        e.id  = 2'(id);
        e.cnt = 8'(cnt);
        expq.push_back(e);
    endtask

    task automatic run_drain(input string name, input int limit);
        int guard = 0;
        while ((any_pending() || busy) && guard < limit) begin
            tick();
            guard++;
        end
        if (guard >= limit) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: got %0d cycles, required fewer than %0d", name, guard, limit);
        end
        repeat (4) tick();
    endtask

    task automatic wait_cons(input int id, input int n, input int limit);
        int guard = 0;
        while (cons_cnt[id] < n && guard < limit) begin
            tick();
            guard++;
        end
        if (guard >= limit) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL wait_cons%0d_timeout: got %0d bits, required %0d", id, cons_cnt[id], n);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req    = '0;
        bit_in = '0;
        for (int i = 0; i < NR; i++) begin
            bq[i].delete();
            cons_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Split the grant log into nonzero runs and compare to expected runs.
    task automatic analyze(input string name, input int nexp, input int ev[8], input int el[8]);
        int sv [$];
        int sl [$];
        int gaps [$];
        int zc = 0;
        logic [NR-1:0] prev = '0;
        for (int i = 0; i < glog.size(); i++) begin
            if (glog[i] == '0) begin
                zc++;
            end else begin
                if (glog[i] == prev && zc == 0) begin
                    sl[sl.size() - 1] = sl[sl.size() - 1] + 1;
                end else begin
                    if (sv.size() > 0) gaps.push_back(zc);
                    sv.push_back(int'(glog[i]));
                    sl.push_back(1);
                end
                zc = 0;
            end
            prev = glog[i];
        end
        chk({name, "_nseg"}, 32'(sv.size()), 32'(nexp));
        for (int s = 0; s < nexp && s < sv.size(); s++) begin
            chk($sformatf("%s_grant%0d", name, s), 32'(sv[s]), 32'(ev[s]));
            chk($sformatf("%s_len%0d", name, s), 32'(sl[s]), 32'(el[s]));
        end
        for (int g = 0; g < gaps.size(); g++)
            chk($sformatf("%s_gap%0d", name, g), 32'(gaps[g]), 32'd1);
        glog.delete();
    endtask

    initial begin
        int t0;
        int ev [8];
        int el [8];

        // Reset state
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_found_id", 32'(found_id), 0);
        chk("rst_hit_count", 32'(hit_count), 0);
        chk("rst_busy", 32'(busy), 0);

        // Single requester: 1101101 -> hits on bits 4 and 7, 3-cycle first-bit latency
        load(0, 7, 32'b1101101);
        push_exp(0, 1);
        push_exp(0, 2);
        tick();
        t0 = cyc;
        wait_cons(0, 1, 20);
        chk("req_to_first_bit", 32'(cyc - t0), 3);
        run_drain("single", 100);
        chk("single_hit_count", 32'(hit_count), 2);
        chk("single_pending", 32'(expq.size()), 0);

        // Fairness: all four requesting, bursts of 8, order 0,1,2,3,0
        do_reset();
        load(0, 16, 32'h0000);
        load(1, 8, 32'h00);
        load(2, 8, 32'b11010000);
        load(3, 8, 32'h00);
        push_exp(2, 1);
        log_en = 1'b1;
        run_drain("fair", 200);
        log_en = 1'b0;
        ev = '{1, 2, 4, 8, 1, 0, 0, 0};
        el = '{8, 8, 8, 8, 8, 0, 0, 0};
        analyze("fair", 5, ev, el);
        chk("fair_pending", 32'(expq.size()), 0);

        // Context carry: req0 sends 1,1, yields to req1, then 0,1 completes 1101
        do_reset();
        load(0, 2, 32'b11);
        load(1, 3, 32'b000);
        push_exp(0, 1);
        wait_cons(1, 3, 50);
        load(0, 2, 32'b01);
        run_drain("carry", 100);
        chk("carry_hit_count", 32'(hit_count), 1);
        chk("carry_pending", 32'(expq.size()), 0);

        // Early release: req2 drops after 3 bits, req3 granted after one ARB cycle
        do_reset();
        load(2, 3, 32'b110);
        load(3, 2, 32'b10);
        log_en = 1'b1;
        run_drain("early", 100);
        log_en = 1'b0;
        ev = '{4, 8, 0, 0, 0, 0, 0, 0};
        el = '{4, 3, 0, 0, 0, 0, 0, 0};
        analyze("early", 2, ev, el);
        chk("early_bits2", 32'(cons_cnt[2]), 3);
        chk("early_bits3", 32'(cons_cnt[3]), 2);
        load(2, 1, 32'b1);
        push_exp(2, 1);
        run_drain("early_ctx", 50);
        chk("early_pending", 32'(expq.size()), 0);

        // Reset mid-burst: ctx1 saved as 110, req0 mid 110; reset clears everything
        load(1, 3, 32'b110);
        run_drain("mid_pre", 50);
        load(0, 4, 32'b1101);
        wait_cons(0, 3, 50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_found", 32'(found), 0);
        chk("midrst_hit_count", 32'(hit_count), 0);
        for (int i = 0; i < NR; i++) begin
            bq[i].delete();
            cons_cnt[i] = 0;
        end
        load(0, 1, 32'b1);
        load(1, 1, 32'b1);
        run_drain("mid_post", 50);
        chk("midrst_hit_after", 32'(hit_count), 0);

        // Saturation: 260 overlapping hits, count sticks at 255
        do_reset();
        load(0, 1, 32'b1);
        for (int k = 1; k <= 260; k++) begin
            load(0, 3, 32'b101);
            push_exp(0, (k > 255) ? 255 : k);
        end
        run_drain("sat", 3000);
        chk("sat_hit_count", 32'(hit_count), 255);
        chk("sat_pending", 32'(expq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
